// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port byte memory among N_REQ
// requesters: IDLE (arbitrate, latch) -> ACCESS (chip enable) -> COMPLETE (ack).
module mem_access_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           req_we,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  output logic [N_REQ-1:0]           ack,
  output logic [DATA_W-1:0]          rdata,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       mem_rw,
  output logic                       mem_ce
);

  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_COMPLETE} state_t;

  state_t              state;
  logic [IDW-1:0]      ptr;
  logic [IDW-1:0]      idx;
  logic [IDW-1:0]      win;
  logic [IDW-1:0]      ptr_next;
  logic                found;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // First active request at or above ptr, wrapping modulo N_REQ.
  always_comb begin
    found     = 1'b0;
    win       = '0;
    idx       = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = IDW'((32'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        found     = 1'b1;
        win       = idx;
        sel_we    = req_we[idx];
        sel_addr  = req_addr[idx*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[idx*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_next = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

  // mem_addr/mem_wdata/mem_rw double as the request latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      ack       <= '0;
      rdata     <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rw    <= 1'b0;
      mem_ce    <= 1'b0;
    end else begin
      ack <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            grant_id  <= win;
            mem_rw    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_ce    <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          mem_ce <= 1'b0;
          if (!mem_rw) rdata <= mem_rdata;
          ack[grant_id] <= 1'b1;
          ptr    <= ptr_next;
          state  <= S_COMPLETE;
        end
        S_COMPLETE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
